// File: rtl/i2c_arbiter_if.sv
// Master-side bus between the arbiter and the shared i2c_top engine.
// The arbiter uses the master modport, the engine the slave modport.
interface i2c_arbiter_if;
    logic       m_en;
    logic [6:0] m_address;
    logic       m_rw;
    logic [7:0] m_data_in;
    logic [3:0] m_N_byte;
    logic [7:0] m_data_out;
    logic       m_byte_done;
    logic       m_busy;

    modport master (
        output m_en,
        output m_address,
        output m_rw,
        output m_data_in,
        output m_N_byte,
        input  m_data_out,
        input  m_byte_done,
        input  m_busy
    );

    modport slave (
        input  m_en,
        input  m_address,
        input  m_rw,
        input  m_data_in,
        input  m_N_byte,
        output m_data_out,
        output m_byte_done,
        output m_busy
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c master between two requesters,
// with byte pacing, read-data return and a progress timeout.
module i2c_arbiter #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [3:0] nb0,
    input  logic [3:0] nb1,
    input  logic [7:0] wd0,
    input  logic [7:0] wd1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       wd_pop0,
    output logic       wd_pop1,
    output logic [7:0] rdata,
    output logic       rd_vld0,
    output logic       rd_vld1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    i2c_arbiter_if.master m
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LAUNCH,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [16:0] TLIM = 17'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_win;
    logic [6:0]  r_addr;
    logic        r_rw;
    logic [3:0]  r_nb;
    logic [3:0]  r_cnt;
    logic [16:0] r_tcnt;
    logic        r_tout;
    logic [7:0]  r_rdata;
    logic        r_rdv0;
    logic        r_rdv1;
    logic        r_err0;
    logic        r_err1;

    logic        w_req;
    logic        w_own;
    logic        w_bd;
    logic        w_tlim;
    logic        w_last_byte;
    logic [3:0]  w_nb_win;

    assign w_req       = req0 | req1;
    assign w_own       = (r_state != IDLE);
    assign w_bd        = (r_state == RUN) && m.m_byte_done;
    assign w_tlim      = (r_tcnt == TLIM);
    assign w_last_byte = w_bd && ((r_cnt + 4'd1) == r_nb);
    assign w_nb_win    = r_win ? nb1 : nb0;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        wd_pop0     = 1'b0;
        wd_pop1     = 1'b0;
        done0       = 1'b0;
        done1       = 1'b0;
        m.m_en      = 1'b0;
        m.m_data_in = 8'd0;

        unique case (r_state)
            IDLE:   if (w_req) w_next = GRANT;
            GRANT:  w_next = (w_nb_win == 4'd0) ? FINISH : LAUNCH;
            LAUNCH: w_next = RUN;
            RUN: begin
                if (w_last_byte)
                    w_next = DRAIN;
                else if (!m.m_byte_done && w_tlim)
                    w_next = DRAIN;
            end
            DRAIN: begin
                // after a timeout, a second window bounds the wait for m_busy
                if (!m.m_busy)
                    w_next = FINISH;
                else if (!m.m_byte_done && w_tlim && r_tout)
                    w_next = FINISH;
            end
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase

        gnt0   = w_own & ~r_win;
        gnt1   = w_own &  r_win;
        m.m_en = (r_state == LAUNCH) || (r_state == RUN);
        if (w_own)
            m.m_data_in = r_win ? wd1 : wd0;
        wd_pop0 = w_bd & ~r_rw & ~r_win;
        wd_pop1 = w_bd & ~r_rw &  r_win;
        done0   = (r_state == FINISH) & ~r_tout & ~r_win;
        done1   = (r_state == FINISH) & ~r_tout &  r_win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_win   <= 1'b0;
            r_addr  <= 7'd0;
            r_rw    <= 1'b0;
            r_nb    <= 4'd0;
            r_cnt   <= 4'd0;
            r_tcnt  <= 17'd0;
            r_tout  <= 1'b0;
            r_rdata <= 8'd0;
            r_rdv0  <= 1'b0;
            r_rdv1  <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            r_rdv0 <= 1'b0;
            r_rdv1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_req)
                        r_win <= (req0 & req1) ? ~r_last : req1;
                end
                GRANT: begin
                    r_addr <= r_win ? addr1 : addr0;
                    r_rw   <= r_win ? rw1 : rw0;
                    r_nb   <= w_nb_win;
                    r_cnt  <= 4'd0;
                    r_tcnt <= 17'd0;
                    r_tout <= 1'b0;
                end
                LAUNCH: r_tcnt <= 17'd0;
                RUN: begin
                    if (m.m_byte_done) begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_tcnt <= 17'd0;
                        if (r_rw) begin
                            r_rdata <= m.m_data_out;
                            r_rdv0  <= ~r_win;
                            r_rdv1  <= r_win;
                        end
                    end else if (w_tlim) begin
                        r_tcnt <= 17'd0;
                        r_tout <= 1'b1;
                        r_err0 <= ~r_win;
                        r_err1 <= r_win;
                    end else begin
                        r_tcnt <= r_tcnt + 17'd1;
                    end
                end
                DRAIN: begin
                    if (m.m_byte_done) begin
                        r_tcnt <= 17'd0;
                    end else if (w_tlim && m.m_busy && !r_tout) begin
                        r_tcnt <= 17'd0;
                        r_tout <= 1'b1;
                        r_err0 <= ~r_win;
                        r_err1 <= r_win;
                    end else begin
                        r_tcnt <= r_tcnt + 17'd1;
                    end
                end
                FINISH: r_last <= r_win;
                default: ;
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign rd_vld0     = r_rdv0;
    assign rd_vld1     = r_rdv1;
    assign err0        = r_err0;
    assign err1        = r_err1;
    assign m.m_address = r_addr;
    assign m.m_rw      = r_rw;
    assign m.m_N_byte  = r_nb;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: a behavioural i2c engine plus a transaction-level
// reference model (round-robin pointer, byte lists) judge every transaction.
module tb_i2c_arbiter;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, rw0, rw1;
    logic [6:0] addr0, addr1;
    logic [3:0] nb0, nb1;
    logic [7:0] wd0, wd1;
    logic       gnt0, gnt1, wd_pop0, wd_pop1;
    logic [7:0] rdata;
    logic       rd_vld0, rd_vld1, done0, done1, err0, err1;

    i2c_arbiter_if bus ();

    i2c_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .rw0(rw0), .rw1(rw1),
        .nb0(nb0), .nb1(nb1),
        .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1),
        .wd_pop0(wd_pop0), .wd_pop1(wd_pop1),
        .rdata(rdata),
        .rd_vld0(rd_vld0), .rd_vld1(rd_vld1),
        .done0(done0), .done1(done1),
        .err0(err0), .err1(err1),
        .m(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last = 1;
    int prev_d = -1;
    int pat;

    int n_pop[2], n_rdv[2], n_done[2], n_err[2];
    int n_en, n_ovl, who, nbd, wi[2];
    int g_cyc, d_cyc, e_cyc, bz_cyc, en_cyc, bd_cyc;
    logic s_gnt;
    logic [6:0] c_addr;
    logic       c_rw;
    logic [3:0] c_nb;
    logic [7:0] rq[$];
    logic [7:0] wq[$];
    logic [7:0] wdat[2][16];
    logic [7:0] rbus[32];
    logic [6:0] t_addr[2];
    logic       t_rw[2];
    logic [3:0] t_nb[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {20'd0, gnt0, gnt1, wd_pop0, wd_pop1,
            rd_vld0, rd_vld1, done0, done1, err0, err1,
            bus.m_en, bus.m_rw}, 32'd0);
        chk({tag, "_dat"}, {5'd0, bus.m_address, bus.m_N_byte,
            bus.m_data_in, rdata}, 32'd0);
    endtask

    task automatic drive_fields();
        addr0 = t_addr[0]; addr1 = t_addr[1];
        rw0 = t_rw[0]; rw1 = t_rw[1];
        nb0 = t_nb[0]; nb1 = t_nb[1];
        wd0 = wdat[0][wi[0]];
        wd1 = wdat[1][wi[1]];
    endtask

    task automatic clear();
        n_pop = '{0, 0}; n_rdv = '{0, 0};
        n_done = '{0, 0}; n_err = '{0, 0};
        wi = '{0, 0};
        n_en = 0; n_ovl = 0; who = -1; nbd = 0;
        g_cyc = -1; d_cyc = -1; e_cyc = -1;
        bz_cyc = -1; en_cyc = -1; bd_cyc = -1;
        c_addr = '0; c_rw = 1'b0; c_nb = '0; s_gnt = 1'b0;
        rq.delete(); wq.delete();
        drive_fields();
    endtask

    task automatic sample();
        s_gnt = gnt0 | gnt1;
        if (gnt0 && gnt1) n_ovl++;
        if (who < 0 && (gnt0 || gnt1)) begin
            who = gnt1 ? 1 : 0;
            g_cyc = cyc;
        end
        if (wd_pop0) begin n_pop[0]++; wq.push_back(bus.m_data_in); wi[0]++; end
        if (wd_pop1) begin n_pop[1]++; wq.push_back(bus.m_data_in); wi[1]++; end
        if (rd_vld0) begin n_rdv[0]++; rq.push_back(rdata); end
        if (rd_vld1) begin n_rdv[1]++; rq.push_back(rdata); end
        if (done0) begin n_done[0]++; d_cyc = cyc; end
        if (done1) begin n_done[1]++; d_cyc = cyc; end
        if (err0) begin n_err[0]++; e_cyc = cyc; end
        if (err1) begin n_err[1]++; e_cyc = cyc; end
        if (bus.m_en) begin
            if (n_en == 0) begin
                c_addr = bus.m_address;
                c_rw = bus.m_rw;
                c_nb = bus.m_N_byte;
            end
            n_en++;
            en_cyc = cyc;
        end
        if (bus.m_busy) bz_cyc = cyc;
        if (bus.m_byte_done) begin
            nbd++;
            if (nbd == int'(c_nb)) bd_cyc = cyc;
        end
    endtask

    // inputs change 1ns after posedge; outputs are sampled at negedge
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        drive_fields();
    endtask

    task automatic txn(input bit r0, input bit r1, input bit keep,
                       input bit drop, input int extra, input bit stall);
        int w, bcnt, gap, dly, bzw;
        bit started, sent, ended, fin;
        int nbw;
        bit rww;
        w = (r0 && r1) ? (1 - last) : (r1 ? 1 : 0);
        nbw = int'(t_nb[w]);
        rww = t_rw[w];
        clear();
        req0 = r0; req1 = r1;
        bus.m_busy = 1'b0; bus.m_byte_done = 1'b0;
        started = 0; sent = 0; ended = 0; fin = 0;
        bcnt = 0; gap = 0; dly = 0; bzw = 0;
        for (int c = 0; c < 600 && !fin; c++) begin
            bus.m_byte_done = 1'b0;
            if (drop && !keep && who >= 0) begin
                if (who == 0) req0 = 1'b0;
                else req1 = 1'b0;
            end
            if (started && !sent && !stall) begin
                if (gap > 0) gap--;
                else begin
                    bus.m_byte_done = 1'b1;
                    bus.m_data_out = rbus[bcnt];
                    bcnt++;
                    gap = $urandom_range(0, 3);
                    if (bcnt == int'(c_nb) + extra) begin
                        sent = 1;
                        dly = $urandom_range(0, 4);
                    end
                end
            end else if (sent) begin
                if (dly > 0) dly--;
                else bus.m_busy = 1'b0;
            end
            if (started && stall) begin
                bzw++;
                if (bzw > 30) bus.m_busy = 1'b0;
            end
            if (!started && n_en > 0) begin
                started = 1;
                bus.m_busy = 1'b1;
                gap = $urandom_range(0, 2);
            end
            step();
            if (!ended && (n_done[0] + n_done[1] + n_err[0] + n_err[1]) > 0) begin
                ended = 1;
                if (!keep) begin req0 = 1'b0; req1 = 1'b0; end
            end else if (ended && !s_gnt) begin
                fin = 1;
            end
        end
        chk("txn_end", fin, 1);
        chk("winner", who, w);
        chk("overlap", n_ovl, 0);
        if (prev_d >= 0) chk("regrant_gap", (g_cyc - prev_d) >= 2, 1);
        chk("other_done", n_done[1-w] + n_err[1-w], 0);
        chk("other_data", n_pop[1-w] + n_rdv[1-w], 0);
        if (stall) begin
            chk("to_en_cycles", n_en, TO + 1);
            chk("to_err", n_err[w], 1);
            chk("to_nodone", n_done[w], 0);
        end else if (nbw == 0) begin
            chk("nb0_en", n_en, 0);
            chk("nb0_done", n_done[w], 1);
            chk("nb0_err", n_err[w], 0);
        end else begin
            chk("addr", c_addr, t_addr[w]);
            chk("rw", c_rw, rww);
            chk("nbyte", c_nb, t_nb[w]);
            chk("pops", n_pop[w], rww ? 0 : nbw);
            chk("rdvld", n_rdv[w], rww ? nbw : 0);
            chk("done", n_done[w], 1);
            chk("err", n_err[w], 0);
            chk("en_drop", en_cyc, bd_cyc);
            chk("done_after_busy", d_cyc > bz_cyc, 1);
            for (int i = 0; i < nbw; i++) begin
                if (rww && i < rq.size())
                    chk("rdata", rq[i], rbus[i]);
                if (!rww && i < wq.size())
                    chk("wdata", wq[i], wdat[w][i]);
            end
        end
        last = w;
        prev_d = (d_cyc >= 0) ? d_cyc : e_cyc;
    endtask

    task automatic randomize_fields();
        for (int j = 0; j < 2; j++) begin
            t_addr[j] = 7'($urandom);
            t_rw[j] = 1'($urandom_range(0, 1));
            t_nb[j] = 4'($urandom_range(0, 6));
            for (int i = 0; i < 16; i++) wdat[j][i] = 8'($urandom);
        end
        for (int i = 0; i < 32; i++) rbus[i] = 8'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        bus.m_byte_done = 1'b0; bus.m_busy = 1'b0; bus.m_data_out = 8'd0;
        randomize_fields();
        clear();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        step();

        t_addr[0] = 7'h10; t_rw[0] = 1'b0; t_nb[0] = 4'd3;
        txn(1, 0, 0, 0, 0, 0);

        randomize_fields();
        t_rw[1] = 1'b1; t_nb[1] = 4'd2;
        rbus[0] = 8'hA5; rbus[1] = 8'h3C;
        txn(0, 1, 0, 0, 0, 0);

        for (int k = 0; k < 3; k++) begin
            randomize_fields();
            t_nb[0] = 4'd2; t_nb[1] = 4'd3;
            txn(1, 1, k < 2, 0, 0, 0);
        end

        randomize_fields();
        t_nb[0] = 4'd0;
        txn(1, 0, 0, 0, 0, 0);

        randomize_fields();
        t_nb[0] = 4'd3;
        txn(1, 0, 0, 0, 0, 1);

        randomize_fields();
        t_nb[0] = 4'd4; t_rw[0] = 1'b0;
        clear();
        req0 = 1'b1; req1 = 1'b0;
        bus.m_busy = 1'b0; bus.m_byte_done = 1'b0;
        for (int c = 0; c < 50 && n_en < 3; c++) begin
            if (n_en > 0) bus.m_busy = 1'b1;
            step();
        end
        chk("rst_in_run", n_en >= 3, 1);
        reset = 1'b1;
        step();
        chk_zero("rst_mid");
        reset = 1'b0;
        req0 = 1'b0;
        bus.m_busy = 1'b0;
        clear();
        repeat (4) step();
        chk("rst_no_pulse", n_done[0] + n_done[1] + n_err[0] + n_err[1], 0);
        chk("rst_no_gnt", who, -1);
        last = 1;
        prev_d = -1;
        randomize_fields();
        t_nb[0] = 4'd2; t_nb[1] = 4'd2;
        txn(1, 1, 0, 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            randomize_fields();
            pat = $urandom_range(1, 3);
            txn(pat[0], pat[1], 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
